// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and encodings for the multiply/divide unit
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = $clog2(DATA_W);

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'b00,
      MDU_RUN  = 2'b01,
      MDU_FIX  = 2'b10
   } mdu_state_e;

endpackage

// File: rtl/mdu_datapath.sv
// rtl/mdu_datapath.sv - shift-add / restoring-divide datapath holding HI/LO
module mdu_datapath
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              iter_i,
   input  logic              fix_i,
   input  logic              mthi_i,
   input  logic              mtlo_i,
   input  logic [1:0]        op_i,
   input  logic [DATA_W-1:0] src_a_i,
   input  logic [DATA_W-1:0] src_b_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   logic [2*DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic                is_div_q, is_div_d;
   logic                neg_q_q, neg_q_d;
   logic                neg_r_q, neg_r_d;

   logic                signed_op, sa, sb;
   logic [DATA_W-1:0]   mag_a, mag_b;
   logic [DATA_W:0]     sum;
   logic [2*DATA_W:0]   sh;
   logic                ge;
   logic [DATA_W-1:0]   diff;
   logic [2*DATA_W-1:0] mul_next, div_next, prod;
   logic [DATA_W-1:0]   quo, rem;

   always_comb begin
      signed_op = (op_i == MDU_MULT) || (op_i == MDU_DIV);
      sa        = signed_op & src_a_i[DATA_W-1];
      sb        = signed_op & src_b_i[DATA_W-1];
      mag_a     = sa ? -src_a_i : src_a_i;
      mag_b     = sb ? -src_b_i : src_b_i;

      // Multiply: multiplier sits in acc low half and shifts out as the product shifts in.
      sum      = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, b_q};
      mul_next = acc_q[0] ? {sum, acc_q[DATA_W-1:1]} : {1'b0, acc_q[2*DATA_W-1:1]};

      // Divide: true trial difference is below the divisor, so it fits in DATA_W bits.
      sh       = {acc_q, 1'b0};
      ge       = sh[2*DATA_W:DATA_W] >= {1'b0, b_q};
      diff     = sh[2*DATA_W-1:DATA_W] - b_q;
      div_next = ge ? {diff, sh[DATA_W-1:1], 1'b1} : sh[2*DATA_W-1:0];

      prod = neg_q_q ? -acc_q : acc_q;
      quo  = neg_q_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
      rem  = neg_r_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

      acc_d    = acc_q;
      b_d      = b_q;
      is_div_d = is_div_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      if (load_i) begin
         acc_d    = {{DATA_W{1'b0}}, mag_a};
         b_d      = mag_b;
         is_div_d = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
         neg_q_d  = sa ^ sb;
         neg_r_d  = sa;
      end else if (iter_i) begin
         acc_d = is_div_q ? div_next : mul_next;
      end else if (fix_i) begin
         hi_d = is_div_q ? rem : prod[2*DATA_W-1:DATA_W];
         lo_d = is_div_q ? quo : prod[DATA_W-1:0];
      end else begin
         if (mthi_i) hi_d = wr_data_i;
         if (mtlo_i) lo_d = wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         b_q      <= '0;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         acc_q    <= acc_d;
         b_q      <= b_d;
         is_div_q <= is_div_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/DIV unit with HI/LO, busy and done
module mult_div_unit
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic              mthi,
   input  logic              mtlo,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              busy,
   output logic              done
);

   mdu_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             done_q;
   logic             idle, load, iter, fix;

   assign idle = (state_q == MDU_IDLE);
   assign load = idle & start;
   assign iter = (state_q == MDU_RUN);
   assign fix  = (state_q == MDU_FIX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MDU_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            MDU_IDLE: begin
               if (start) begin
                  state_q <= MDU_RUN;
                  cnt_q   <= '0;
               end
            end
            MDU_RUN: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= MDU_FIX;
            end
            MDU_FIX: begin
               state_q <= MDU_IDLE;
               done_q  <= 1'b1;
            end
            default: state_q <= MDU_IDLE;
         endcase
      end
   end

   // Moves are only honoured in IDLE and lose to a simultaneous start.
   mdu_datapath u_datapath (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load),
      .iter_i    (iter),
      .fix_i     (fix),
      .mthi_i    (idle & ~start & mthi),
      .mtlo_i    (idle & ~start & mtlo),
      .op_i      (op),
      .src_a_i   (src_a),
      .src_b_i   (src_b),
      .wr_data_i (wr_data),
      .hi_o      (hi),
      .lo_o      (lo)
   );

   assign busy = ~idle;
   assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic [31:0] wr_data = '0;
   logic [31:0] hi, lo;
   logic        busy, done;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eh;
      logic [31:0] el;
   } vec_t;

   vec_t vecs[7];

   mult_div_unit dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .src_a   (src_a),
      .src_b   (src_b),
      .mthi    (mthi),
      .mtlo    (mtlo),
      .wr_data (wr_data),
      .hi      (hi),
      .lo      (lo),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic; SV division already truncates toward zero.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa64, sb64, p;
      logic [63:0]        q, r;
      sa64 = {{32{a[31]}}, a};
      sb64 = {{32{b[31]}}, b};
      case (o)
         MDU_MULT:  begin p = sa64 * sb64; return p; end
         MDU_MULTU: return {32'b0, a} * {32'b0, b};
         MDU_DIV: begin
            if (b == 0) return {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
            q = sa64 / sb64;
            r = sa64 % sb64;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // inj_kind: 0 none, 1 mtlo during RUN, 2 second start during RUN, 3 mthi together with start
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inj_cyc, input int inj_kind,
                         output logic [31:0] rh, output logic [31:0] rl);
      int          n = 0;
      int          bcnt = 0;
      logic [31:0] h0, l0;
      logic        stable = 1'b1;
      @(negedge clk);
      op = o; src_a = a; src_b = b; start = 1'b1;
      if (inj_kind == 3) begin mthi = 1'b1; wr_data = $urandom; end
      h0 = hi; l0 = lo;
      @(negedge clk);
      start = 1'b0; mthi = 1'b0;
      src_a = $urandom; src_b = $urandom; op = 2'($urandom);
      while (!done && n < 100) begin
         if (busy) bcnt++;
         if (hi !== h0 || lo !== l0) stable = 1'b0;
         mtlo = 1'b0; start = 1'b0;
         if (n == inj_cyc && inj_kind == 1) begin mtlo = 1'b1; wr_data = $urandom; end
         if (n == inj_cyc && inj_kind == 2) begin start = 1'b1; op = 2'($urandom); end
         @(negedge clk);
         n++;
      end
      mtlo = 1'b0; start = 1'b0;
      check("done_seen", 32'(done), 32'd1);
      check("busy_cycles", 32'(bcnt), 32'd33);
      check("busy_at_done", 32'(busy), 32'd0);
      check("hilo_stable_in_run", 32'(stable), 32'd1);
      rh = hi; rl = lo;
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      logic [31:0] rh, rl;
      logic [63:0] exp;
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      logic        seen;

      vecs[0] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1] = '{MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[4] = '{MDU_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
      vecs[5] = '{MDU_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0001};
      vecs[6] = '{MDU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

      repeat (2) @(negedge clk);
      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, 0, rh, rl);
         check($sformatf("vec%0d_hi", i), rh, vecs[i].eh);
         check($sformatf("vec%0d_lo", i), rl, vecs[i].el);
      end

      @(negedge clk); mthi = 1'b1; wr_data = 32'hAAAA_5555;
      @(negedge clk); mthi = 1'b0;
      check("mthi_idle", hi, 32'hAAAA_5555);
      @(negedge clk); mtlo = 1'b1; wr_data = 32'h1357_9BDF;
      @(negedge clk); mtlo = 1'b0;
      check("mtlo_idle", lo, 32'h1357_9BDF);
      check("mtlo_keeps_hi", hi, 32'hAAAA_5555);
      @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h0F0F_1234;
      @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
      check("both_mv_hi", hi, 32'h0F0F_1234);
      check("both_mv_lo", lo, 32'h0F0F_1234);

      run_op(MDU_MULTU, 32'd3, 32'd5, 6, 1, rh, rl);
      check("mtlo_run_hi", rh, 32'd0);
      check("mtlo_run_lo", rl, 32'd15);
      run_op(MDU_DIVU, 32'd100, 32'd7, 5, 2, rh, rl);
      check("restart_hi", rh, 32'd2);
      check("restart_lo", rl, 32'd14);
      run_op(MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 3, rh, rl);
      check("start_beats_mthi_hi", rh, 32'd0);
      check("start_beats_mthi_lo", rl, 32'd1);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom);
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
         exp = model(ro, ra, rb);
         run_op(ro, ra, rb, -1, 0, rh, rl);
         check($sformatf("rand%0d_op%0d_%h_%h_hi", i, ro, ra, rb), rh, exp[63:32]);
         check($sformatf("rand%0d_op%0d_%h_%h_lo", i, ro, ra, rb), rl, exp[31:0]);
      end

      @(negedge clk);
      op = MDU_MULT; src_a = 32'h0001_0003; src_b = 32'h0000_0101; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (9) @(negedge clk);
      check("pre_reset_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_hi", hi, 32'h0);
      check("async_reset_lo", lo, 32'h0);
      check("async_reset_busy", 32'(busy), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      check("no_done_after_abort", 32'(seen), 32'd0);
      check("abort_hi_clear", hi, 32'h0);
      check("abort_lo_clear", lo, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the register file read ports.
- It consumes read_data_1/read_data_2 as src_a/src_b for MULT, MULTU, DIV and DIVU, and accepts MTHI/MTLO writes.
- It drives hi/lo to the writeback mux for MFHI/MFLO.
- It raises busy so the PC/control can stall an MFHI/MFLO or a new mult/div issued while an operation is in flight.

Parameters:
- DATA_W, 32, operand width. HI and LO are each DATA_W; the product is 2*DATA_W; the iteration count equals DATA_W.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request to launch op; sampled only in IDLE.
- op, input, 2, operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a, input, DATA_W, multiplicand / dividend (rs).
- src_b, input, DATA_W, multiplier / divisor (rt).
- mthi, input, 1, write wr_data into HI.
- mtlo, input, 1, write wr_data into LO.
- wr_data, input, DATA_W, data for mthi/mtlo.
- hi, output, DATA_W, HI register: product upper half / remainder.
- lo, output, DATA_W, LO register: product lower half / quotient.
- busy, output, 1, high while state != IDLE.
- done, output, 1, one-cycle pulse after HI/LO are updated by an operation.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0, working registers=0. Reset mid-operation aborts the operation; no partial result reaches HI/LO.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge E0:
  - Latch op and the sign flags sa=src_a[31], sb=src_b[31] (signed ops only).
  - Latch magnitudes |src_a| and |src_b| for signed ops, raw values for unsigned ops.
  - Clear the 2*DATA_W accumulator and counter; go to RUN.
- RUN, edges E1..E32: one iteration per edge.
  - Multiply: shift-add on the LSB of the multiplier.
  - Divide: restoring shift-subtract; a quotient bit is 1 when the trial remainder is >= 0.
  - The counter increments; at count == DATA_W-1 go to FIX.
- FIX, edge E33:
  - Apply sign correction.
    - Signed multiply: negate the 64-bit product if sa^sb.
    - Signed divide: negate the quotient if sa^sb; negate the remainder if sa.
  - Write HI/LO and go to IDLE.
  - done=1 for the single cycle following E33.
- Latency: start to HI/LO valid is 33 clocks. busy is high for exactly 33 cycles; busy=0 in the cycle done=1.
- Results and boundaries:
  - Divide results truncate toward zero.
  - Signed divide 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude arithmetic and is required.
  - Divide by zero (no trap): HI=src_a.
    - DIVU: LO=0xFFFFFFFF.
    - DIV: LO=0xFFFFFFFF if src_a >= 0, else 0x00000001.
  - Operands are captured at E0; later changes to src_a/src_b during RUN have no effect.
- Priority and conflicts:
  - start while busy: ignored. Control must hold the instruction using busy.
  - mthi/mtlo while busy: ignored.
  - In IDLE, start together with mthi/mtlo: start wins; the move is ignored.
  - mthi and mtlo both high in IDLE: both write wr_data.
- hi/lo change only on a FIX edge, an accepted mthi/mtlo edge, or reset. They are stable otherwise, including throughout RUN, so they still hold the previous result.

Decomposition:
- Shared package mips_pkg holds:
  - op codes MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11;
  - state encodings MDU_IDLE, MDU_RUN, MDU_FIX;
  - DATA_W.
- One natural sub-module: mdu_datapath, holding the accumulator/remainder shift registers and the add/subtract step, driven by an iterate/load/fix strobe from the mult_div_unit FSM.

Test Plan:
- MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> after 33 clks HI=0xFFFFFFFE, LO=0x00000001, done pulse 1 cycle, busy high exactly 33 cycles.
- MULT src_a=0xFFFFFFFD (-3), src_b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV src_a=-7 (0xFFFFFFF9), src_b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU src_a=0x12345678, src_b=0 -> LO=0xFFFFFFFF, HI=0x12345678.
- Conflicts and reset:
  - mthi wr_data=0xAAAA5555 in IDLE -> hi=0xAAAA5555 next edge.
  - mtlo during RUN -> lo unchanged.
  - Second start during RUN -> ignored; original result intact.
  - rst_n low at cycle 10 of a MULT -> hi=lo=0, busy=0 immediately (async), done never pulses.
